// File: rtl/pad_pkg.sv
// Shared types and constants for the drum-pad sense conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pad_pkg;

  // Per-pad debounce FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    PRESSED = 2'd2,
    HOLDOFF = 2'd3
  } pad_state_e;

  localparam int MAX_PADS   = 8;

  // Field offsets inside sensor_word.
  localparam int LEVEL_LSB  = 0;
  localparam int STICKY_LSB = 8;
  localparam int SEQ_LSB    = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [3:0] popcount8(input logic [MAX_PADS-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < MAX_PADS; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pad_debounce.sv
// One pad: 2-flop synchronizer, IDLE/CONFIRM/PRESSED/HOLDOFF FSM and counter.
// Latency: hit_pulse_o rises DEBOUNCE_CYCLES+3 edges after a held-high raw input.
// Backpressure: none; pulses are one-cycle strobes that cannot be stalled.
module pad_debounce
  import pad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLDOFF_CYCLES  = 2500000
) (
  input  logic clock,
  input  logic resetn,
  input  logic pad_i,
  output logic hit_pulse_o,
  output logic level_o
);

  // Wide enough for the larger terminal count; counters stop at their last value.
  localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYCLES, HOLDOFF_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  logic             sync1_q, sync2_q;
  pad_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             level_q;

  // Bring the asynchronous comparator output into the clock domain.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
    end
  end

  // Next-state, counter and hit strobe decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = CONFIRM;
          cnt_d   = '0;
        end
      end
      CONFIRM: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d = HOLDOFF;
          cnt_d   = '0;
        end
      end
      HOLDOFF: begin
        // Input is ignored here so ringing after release cannot retrigger.
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; level tracks the PRESSED state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= (state_d == PRESSED);
    end
  end

  assign hit_pulse_o = pulse_q;
  assign level_o     = level_q;

endmodule

// File: rtl/pad_sense_conditioner.sv
// Debounces NUM_PADS drum pads and packs level/sticky/sequence status into sensor_word.
// Latency: hit_pulse DEBOUNCE_CYCLES+3 after raw rise; sticky/seq/hit_count one cycle later.
// Backpressure: none; optional hit counter enabled by defining PAD_HIT_COUNT_EN.
module pad_sense_conditioner
  import pad_pkg::*;
#(
  parameter int NUM_PADS        = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLDOFF_CYCLES  = 2500000
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [NUM_PADS-1:0] pad_raw,
  input  logic                hit_clr,
  output logic [31:0]         sensor_word,
  output logic [NUM_PADS-1:0] hit_pulse,
  output logic [31:0]         hit_count
);

  logic [NUM_PADS-1:0] level;
  logic [MAX_PADS-1:0] pulse_ext, level_ext;
  logic [MAX_PADS-1:0] sticky_q, sticky_d;
  logic [7:0]          seq_q, seq_d;

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
    pad_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLDOFF_CYCLES  (HOLDOFF_CYCLES)
    ) u_pad (
      .clock       (clock),
      .resetn      (resetn),
      .pad_i       (pad_raw[p]),
      .hit_pulse_o (hit_pulse[p]),
      .level_o     (level[p])
    );
  end

  // Zero-extend per-pad vectors to the fixed 8-bit status fields.
  always_comb begin
    pulse_ext = '0;
    level_ext = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      pulse_ext[i] = hit_pulse[i];
      level_ext[i] = level[i];
    end
  end

  // Sticky flags: a new hit wins over a simultaneous clear. Sequence counts hit cycles.
  always_comb begin
    sticky_d = (sticky_q & ~{MAX_PADS{hit_clr}}) | pulse_ext;
    seq_d    = (|pulse_ext) ? seq_q + 8'd1 : seq_q;
  end

  // Status registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sticky_q <= '0;
      seq_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      seq_q    <= seq_d;
    end
  end

  // Pure wiring of flop outputs into the processor-visible word.
  always_comb begin
    sensor_word = '0;
    sensor_word[LEVEL_LSB  +: MAX_PADS] = level_ext;
    sensor_word[STICKY_LSB +: MAX_PADS] = sticky_q;
    sensor_word[SEQ_LSB    +: 8]        = seq_q;
  end

`ifdef PAD_HIT_COUNT_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [32:0] hit_sum;

  // Saturating total of accepted hits; simultaneous pads each count.
  always_comb begin
    hit_sum     = {1'b0, hit_count_q} + {29'd0, popcount8(pulse_ext)};
    hit_count_d = hit_sum[32] ? 32'hFFFF_FFFF : hit_sum[31:0];
  end

  // Hit counter register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) hit_count_q <= '0;
    else         hit_count_q <= hit_count_d;
  end

  assign hit_count = hit_count_q;
`else
  assign hit_count = 32'd0;
`endif

endmodule

// File: tb/tb_pad_sense_conditioner.sv
// Scoreboard bench: stimulus queues expected hits, a monitor checks each hit_pulse.
// Latency: expected pulse cycle is press edge + DEBOUNCE_CYCLES + 3.
// Backpressure: n/a.
module tb_pad_sense_conditioner;

  localparam int NP = 3;
  localparam int DB = 4;
  localparam int HO = 8;

  logic          clock = 1'b0;
  logic          resetn;
  logic [NP-1:0] pad_raw;
  logic          hit_clr;
  logic [31:0]   sensor_word;
  logic [NP-1:0] hit_pulse;
  logic [31:0]   hit_count;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic [NP-1:0] pulse;
    int            cyc;
    logic [7:0]    seq;
    logic [31:0]   hc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] exp_seq = 8'd0;
  logic [31:0] exp_hc = 32'd0;

  pad_sense_conditioner #(
    .NUM_PADS        (NP),
    .DEBOUNCE_CYCLES (DB),
    .HOLDOFF_CYCLES  (HO)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .pad_raw     (pad_raw),
    .hit_clr     (hit_clr),
    .sensor_word (sensor_word),
    .hit_pulse   (hit_pulse),
    .hit_count   (hit_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Queue one expected hit for pads p, due at edge c.
  task automatic expect_hit(input logic [NP-1:0] p, input int c);
    exp_t e;
    exp_seq = exp_seq + 8'd1;
`ifdef PAD_HIT_COUNT_EN
    exp_hc = exp_hc + 32'(p[0]) + 32'(p[1]) + 32'(p[2]);
`endif
    e.pulse = p;
    e.cyc   = c;
    e.seq   = exp_seq;
    e.hc    = exp_hc;
    exp_q.push_back(e);
  endtask

  // Monitor: every non-zero hit_pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (resetn === 1'b1 && hit_pulse !== '0) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: got %b, expected none (cycle %0d)", hit_pulse, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_pads", 32'(hit_pulse), 32'(mon_e.pulse));
        check("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
        @(negedge clock);
        check("pulse_width", 32'(hit_pulse), 32'd0);
        check("seq_after", 32'(sensor_word[23:16]), 32'(mon_e.seq));
        check("count_after", hit_count, mon_e.hc);
      end
    end
  end

  initial begin
    int c;
    resetn  = 1'b0;
    pad_raw = '0;
    hit_clr = 1'b0;
    #1;
    check("reset_word", sensor_word, 32'h0);
    check("reset_pulse", 32'(hit_pulse), 32'h0);
    check("reset_count", hit_count, 32'h0);
    tick(3);
    resetn = 1'b1;
    tick(2);

    // Bounce on pad 1: three cycles high never completes the debounce.
    pad_raw = 3'b010;
    tick(3);
    pad_raw = 3'b000;
    tick(10);
    check("bounce_word", sensor_word, 32'h0000_0000);

    // Single press on pad 0.
    c = cyc;
    pad_raw = 3'b001;
    expect_hit(3'b001, c + 7);
    tick(10);
    check("press_word", sensor_word, 32'h0001_0101);
    pad_raw = 3'b000;
    tick(20);
    check("release_word", sensor_word, 32'h0001_0100);

    // Pads 0 and 2 together: one sequence step, two counted hits.
    c = cyc;
    pad_raw = 3'b101;
    expect_hit(3'b101, c + 7);
    tick(10);
    check("dual_word", sensor_word, 32'h0002_0505);
    pad_raw = 3'b000;
    tick(20);

    // Clear in the same cycle a new pad-0 hit lands: the hit survives.
    c = cyc;
    pad_raw = 3'b001;
    expect_hit(3'b001, c + 7);
    tick(7);
    hit_clr = 1'b1;
    tick(1);
    hit_clr = 1'b0;
    tick(1);
    check("clr_vs_set", sensor_word, 32'h0003_0101);
    hit_clr = 1'b1;
    tick(1);
    hit_clr = 1'b0;
    tick(1);
    check("clr_alone", 32'(sensor_word[15:8]), 32'h0);

    // Release, re-press inside holdoff and keep holding: one hit 5 cycles after holdoff exit.
    c = cyc;
    pad_raw = 3'b000;
    tick(4);
    pad_raw = 3'b001;
    expect_hit(3'b001, c + 16);
    tick(20);
    check("repress_word", sensor_word, 32'h0004_0101);

    // Reset while pressed and held: everything clears at once.
    resetn = 1'b0;
    #1;
    check("midreset_word", sensor_word, 32'h0);
    check("midreset_count", hit_count, 32'h0);
    exp_seq = 8'd0;
    exp_hc  = 32'd0;
    tick(3);
    c = cyc;
    resetn = 1'b1;
    expect_hit(3'b001, c + 7);
    tick(10);
    check("post_reset_word", sensor_word, 32'h0001_0101);

    // 255 more hits take the sequence number through 255 back to 0.
    for (int k = 0; k < 255; k++) begin
      pad_raw = 3'b000;
      tick(12);
      c = cyc;
      pad_raw = 3'b001;
      expect_hit(3'b001, c + 7);
      tick(9);
    end
    tick(2);
    check("seq_wrap", 32'(sensor_word[23:16]), 32'h0);
`ifdef PAD_HIT_COUNT_EN
    check("count_total", hit_count, 32'd256);
`else
    check("count_total", hit_count, 32'd0);
`endif
    pad_raw = 3'b000;
    tick(20);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
